// File: rtl/lcd_init_seq_if.sv
// Word-writer bus between the ST7789 sequencer and the SPI/8080 write engine.
// The sequencer presents a 9-bit word (bit8=1 data, bit8=0 command) while
// en_write is high; the writer answers with a single-cycle wr_done per word.
interface lcd_init_seq_if;
    logic [8:0] init_data;
    logic       en_write;
    logic       wr_done;

    modport master (
        output init_data,
        output en_write,
        input  wr_done
    );

    modport slave (
        input  init_data,
        input  en_write,
        output wr_done
    );
endinterface

// File: rtl/lcd_init_seq.sv
// ST7789 power-up sequencer and rectangle-fill engine.
// Holds the panel in hardware reset, waits, streams the init table, waits for
// sleep-out, clears the whole screen, then serves run-time rectangle fills.
// Every output is registered. The word index of a write state only moves on
// wr_done, so a slow writer simply stretches the state.
module lcd_init_seq #(
    parameter int          T_RST_LOW  = 5_000_000,
    parameter int          T_RST_WAIT = 2_500_000,
    parameter int          T_SLPOUT   = 6_000_000,
    parameter int          H_RES      = 240,
    parameter int          V_RES      = 320,
    parameter logic [7:0]  MADCTL     = 8'h00,
    parameter logic [15:0] CLR_COLOR  = 16'hFFFF
) (
    input  logic           sys_clk_50MHz,
    input  logic           sys_rst_n,
    lcd_init_seq_if.master wr,
    input  logic           reinit,
    input  logic           fill_req,
    input  logic [8:0]     fill_x0,
    input  logic [8:0]     fill_x1,
    input  logic [8:0]     fill_y0,
    input  logic [8:0]     fill_y1,
    input  logic [15:0]    fill_color,
    output logic           lcd_rst,
    output logic           init_done,
    output logic           fill_done,
    output logic           fill_err
);

    // One counter serves all three delay phases, so it is sized for their sum.
    localparam int DLY_W = $clog2(T_RST_LOW + T_RST_WAIT + T_SLPOUT + 1);
    // Full-screen fill is 2*H*V words; the +1 keeps that count representable.
    localparam int PIX_W = $clog2(2 * H_RES * V_RES + 1);

    localparam logic [DLY_W-1:0] DLY_ZERO      = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE       = DLY_W'(1);
    localparam logic [DLY_W-1:0] RST_LOW_LAST  = DLY_W'(T_RST_LOW - 1);
    localparam logic [DLY_W-1:0] RST_WAIT_LAST = DLY_W'(T_RST_WAIT - 1);
    localparam logic [DLY_W-1:0] SLPOUT_LAST   = DLY_W'(T_SLPOUT - 1);

    localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
    localparam logic [PIX_W-1:0] PIX_CLR  = PIX_W'(2 * H_RES * V_RES);

    localparam logic [8:0] X_MAX = 9'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);
    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    localparam logic [5:0] ROM_LAST = 6'd57;
    localparam logic [3:0] WIN_LAST = 4'd10;

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_ROM      = 3'd2,
        ST_SLP_WAIT = 3'd3,
        ST_WIN      = 3'd4,
        ST_FILL     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t           state_r;
    logic [DLY_W-1:0] dly_cnt_r;
    logic [5:0]       rom_idx_r;
    logic [3:0]       win_idx_r;
    logic [PIX_W-1:0] pix_cnt_r;
    logic [PIX_W-1:0] pix_total_r;
    logic [8:0]       x0_r;
    logic [8:0]       x1_r;
    logic [8:0]       y0_r;
    logic [8:0]       y1_r;
    logic [15:0]      color_r;
    logic             user_fill_r;
    logic             lcd_rst_r;
    logic [8:0]       init_data_r;
    logic             en_write_r;
    logic             init_done_r;
    logic             fill_done_r;
    logic             fill_err_r;

    logic             fill_ok_s;
    logic [9:0]       fill_w_s;
    logic [9:0]       fill_h_s;
    logic [19:0]      fill_area_s;
    logic [PIX_W-1:0] fill_total_s;

    // Init table: command words have bit8=0, parameter words bit8=1.
    function automatic logic [8:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    rom_word = 9'h011;
            6'd1:    rom_word = 9'h036;
            6'd2:    rom_word = {1'b1, MADCTL};
            6'd3:    rom_word = 9'h03a;
            6'd4:    rom_word = 9'h155;
            6'd5:    rom_word = 9'h0b2;
            6'd6:    rom_word = 9'h10c;
            6'd7:    rom_word = 9'h10c;
            6'd8:    rom_word = 9'h100;
            6'd9:    rom_word = 9'h133;
            6'd10:   rom_word = 9'h133;
            6'd11:   rom_word = 9'h0b7;
            6'd12:   rom_word = 9'h135;
            6'd13:   rom_word = 9'h0bb;
            6'd14:   rom_word = 9'h132;
            6'd15:   rom_word = 9'h0c2;
            6'd16:   rom_word = 9'h101;
            6'd17:   rom_word = 9'h0c3;
            6'd18:   rom_word = 9'h115;
            6'd19:   rom_word = 9'h0c4;
            6'd20:   rom_word = 9'h120;
            6'd21:   rom_word = 9'h0c6;
            6'd22:   rom_word = 9'h10f;
            6'd23:   rom_word = 9'h0d0;
            6'd24:   rom_word = 9'h1a4;
            6'd25:   rom_word = 9'h1a1;
            6'd26:   rom_word = 9'h0e0;
            6'd27:   rom_word = 9'h1d0;
            6'd28:   rom_word = 9'h104;
            6'd29:   rom_word = 9'h10d;
            6'd30:   rom_word = 9'h111;
            6'd31:   rom_word = 9'h113;
            6'd32:   rom_word = 9'h12b;
            6'd33:   rom_word = 9'h13f;
            6'd34:   rom_word = 9'h154;
            6'd35:   rom_word = 9'h14c;
            6'd36:   rom_word = 9'h118;
            6'd37:   rom_word = 9'h10d;
            6'd38:   rom_word = 9'h10b;
            6'd39:   rom_word = 9'h11f;
            6'd40:   rom_word = 9'h123;
            6'd41:   rom_word = 9'h0e1;
            6'd42:   rom_word = 9'h1d0;
            6'd43:   rom_word = 9'h104;
            6'd44:   rom_word = 9'h10c;
            6'd45:   rom_word = 9'h111;
            6'd46:   rom_word = 9'h113;
            6'd47:   rom_word = 9'h12c;
            6'd48:   rom_word = 9'h13f;
            6'd49:   rom_word = 9'h144;
            6'd50:   rom_word = 9'h151;
            6'd51:   rom_word = 9'h12f;
            6'd52:   rom_word = 9'h11f;
            6'd53:   rom_word = 9'h11f;
            6'd54:   rom_word = 9'h120;
            6'd55:   rom_word = 9'h123;
            6'd56:   rom_word = 9'h021;
            6'd57:   rom_word = 9'h029;
            default: rom_word = 9'h000;
        endcase
    endfunction

    // CASET / RASET / RAMWR words; coordinates are zero-extended to 16 bits.
    function automatic logic [8:0] win_word(
        input logic [3:0] idx,
        input logic [8:0] x0,
        input logic [8:0] x1,
        input logic [8:0] y0,
        input logic [8:0] y1
    );
        case (idx)
            4'd0:    win_word = 9'h02a;
            4'd1:    win_word = {1'b1, 7'd0, x0[8]};
            4'd2:    win_word = {1'b1, x0[7:0]};
            4'd3:    win_word = {1'b1, 7'd0, x1[8]};
            4'd4:    win_word = {1'b1, x1[7:0]};
            4'd5:    win_word = 9'h02b;
            4'd6:    win_word = {1'b1, 7'd0, y0[8]};
            4'd7:    win_word = {1'b1, y0[7:0]};
            4'd8:    win_word = {1'b1, 7'd0, y1[8]};
            4'd9:    win_word = {1'b1, y1[7:0]};
            4'd10:   win_word = 9'h02c;
            default: win_word = 9'h000;
        endcase
    endfunction

    // Validate a fill request and size its pixel-word stream.
    always_comb begin
        fill_w_s     = {1'b0, fill_x1} - {1'b0, fill_x0} + 10'd1;
        fill_h_s     = {1'b0, fill_y1} - {1'b0, fill_y0} + 10'd1;
        fill_area_s  = fill_w_s * fill_h_s;
        fill_total_s = PIX_W'({fill_area_s, 1'b0});
        if ((fill_x1 >= fill_x0) && (fill_y1 >= fill_y0) &&
            ({1'b0, fill_x1} < H_LIM) && ({1'b0, fill_y1} < V_LIM)) begin
            fill_ok_s = 1'b1;
        end else begin
            fill_ok_s = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered; reinit acts as a soft reset.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_RST_LOW;
            dly_cnt_r   <= DLY_ZERO;
            rom_idx_r   <= 6'd0;
            win_idx_r   <= 4'd0;
            pix_cnt_r   <= PIX_ZERO;
            pix_total_r <= PIX_ZERO;
            x0_r        <= 9'd0;
            x1_r        <= 9'd0;
            y0_r        <= 9'd0;
            y1_r        <= 9'd0;
            color_r     <= 16'h0000;
            user_fill_r <= 1'b0;
            lcd_rst_r   <= 1'b0;
            init_data_r <= 9'h000;
            en_write_r  <= 1'b0;
            init_done_r <= 1'b0;
            fill_done_r <= 1'b0;
            fill_err_r  <= 1'b0;
        end else if (reinit) begin
            state_r     <= ST_RST_LOW;
            dly_cnt_r   <= DLY_ZERO;
            rom_idx_r   <= 6'd0;
            win_idx_r   <= 4'd0;
            pix_cnt_r   <= PIX_ZERO;
            pix_total_r <= PIX_ZERO;
            user_fill_r <= 1'b0;
            lcd_rst_r   <= 1'b0;
            init_data_r <= 9'h000;
            en_write_r  <= 1'b0;
            init_done_r <= 1'b0;
            fill_done_r <= 1'b0;
            fill_err_r  <= 1'b0;
        end else begin
            // Pulses and the delay counter idle low unless a state says otherwise.
            fill_done_r <= 1'b0;
            fill_err_r  <= 1'b0;
            dly_cnt_r   <= DLY_ZERO;
            case (state_r)
                ST_RST_LOW: begin
                    if (dly_cnt_r == RST_LOW_LAST) begin
                        lcd_rst_r <= 1'b1;
                        state_r   <= ST_RST_WAIT;
                    end else begin
                        dly_cnt_r <= dly_cnt_r + DLY_ONE;
                    end
                end
                ST_RST_WAIT: begin
                    if (dly_cnt_r == RST_WAIT_LAST) begin
                        rom_idx_r   <= 6'd0;
                        init_data_r <= rom_word(6'd0);
                        en_write_r  <= 1'b1;
                        state_r     <= ST_ROM;
                    end else begin
                        dly_cnt_r <= dly_cnt_r + DLY_ONE;
                    end
                end
                ST_ROM: begin
                    if (wr.wr_done) begin
                        if (rom_idx_r == ROM_LAST) begin
                            rom_idx_r   <= 6'd0;
                            init_data_r <= 9'h000;
                            en_write_r  <= 1'b0;
                            state_r     <= ST_SLP_WAIT;
                        end else begin
                            rom_idx_r   <= rom_idx_r + 6'd1;
                            init_data_r <= rom_word(rom_idx_r + 6'd1);
                        end
                    end else begin
                        rom_idx_r <= rom_idx_r;
                    end
                end
                ST_SLP_WAIT: begin
                    if (dly_cnt_r == SLPOUT_LAST) begin
                        // Power-up clear: full panel, not reported via fill_done.
                        x0_r        <= 9'd0;
                        x1_r        <= X_MAX;
                        y0_r        <= 9'd0;
                        y1_r        <= Y_MAX;
                        color_r     <= CLR_COLOR;
                        pix_total_r <= PIX_CLR;
                        user_fill_r <= 1'b0;
                        win_idx_r   <= 4'd0;
                        init_data_r <= 9'h02a;
                        en_write_r  <= 1'b1;
                        state_r     <= ST_WIN;
                    end else begin
                        dly_cnt_r <= dly_cnt_r + DLY_ONE;
                    end
                end
                ST_WIN: begin
                    if (wr.wr_done) begin
                        if (win_idx_r == WIN_LAST) begin
                            win_idx_r   <= 4'd0;
                            pix_cnt_r   <= PIX_ZERO;
                            init_data_r <= {1'b1, color_r[15:8]};
                            state_r     <= ST_FILL;
                        end else begin
                            win_idx_r   <= win_idx_r + 4'd1;
                            init_data_r <= win_word(win_idx_r + 4'd1, x0_r, x1_r, y0_r, y1_r);
                        end
                    end else begin
                        win_idx_r <= win_idx_r;
                    end
                end
                ST_FILL: begin
                    if (wr.wr_done) begin
                        if (pix_cnt_r == (pix_total_r - PIX_ONE)) begin
                            pix_cnt_r   <= PIX_ZERO;
                            init_data_r <= 9'h000;
                            en_write_r  <= 1'b0;
                            init_done_r <= 1'b1;
                            fill_done_r <= user_fill_r;
                            state_r     <= ST_DONE;
                        end else begin
                            // Even index was a high byte, so the next word is the low byte.
                            pix_cnt_r   <= pix_cnt_r + PIX_ONE;
                            init_data_r <= pix_cnt_r[0] ? {1'b1, color_r[15:8]}
                                                        : {1'b1, color_r[7:0]};
                        end
                    end else begin
                        pix_cnt_r <= pix_cnt_r;
                    end
                end
                ST_DONE: begin
                    if (fill_req) begin
                        if (fill_ok_s) begin
                            x0_r        <= fill_x0;
                            x1_r        <= fill_x1;
                            y0_r        <= fill_y0;
                            y1_r        <= fill_y1;
                            color_r     <= fill_color;
                            pix_total_r <= fill_total_s;
                            user_fill_r <= 1'b1;
                            win_idx_r   <= 4'd0;
                            init_data_r <= 9'h02a;
                            en_write_r  <= 1'b1;
                            init_done_r <= 1'b0;
                            state_r     <= ST_WIN;
                        end else begin
                            fill_err_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    lcd_rst_r   <= 1'b0;
                    init_data_r <= 9'h000;
                    en_write_r  <= 1'b0;
                    init_done_r <= 1'b0;
                    state_r     <= ST_RST_LOW;
                end
            endcase
        end
    end

    assign wr.init_data = init_data_r;
    assign wr.en_write  = en_write_r;
    assign lcd_rst      = lcd_rst_r;
    assign init_done    = init_done_r;
    assign fill_done    = fill_done_r;
    assign fill_err     = fill_err_r;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Self-checking bench for lcd_init_seq with small timing parameters.
// A writer model acks each word 3 cycles after it sees en_write and records
// the word; expected word streams are built from the command-set rules.
module tb_lcd_init_seq;

    localparam int H = 4;
    localparam int V = 3;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        reinit   = 1'b0;
    logic        fill_req = 1'b0;
    logic [8:0]  fx0      = 9'd0;
    logic [8:0]  fx1      = 9'd0;
    logic [8:0]  fy0      = 9'd0;
    logic [8:0]  fy1      = 9'd0;
    logic [15:0] fcol     = 16'h0000;
    logic        lcd_rst;
    logic        init_done;
    logic        fill_done;
    logic        fill_err;
    logic        ack      = 1'b0;
    logic        stray    = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int fd_cnt      = 0;
    int fe_cnt      = 0;

    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];

    logic [8:0] rom_tbl [58] = '{
        9'h011, 9'h036, 9'h100, 9'h03a, 9'h155,
        9'h0b2, 9'h10c, 9'h10c, 9'h100, 9'h133, 9'h133,
        9'h0b7, 9'h135, 9'h0bb, 9'h132, 9'h0c2, 9'h101,
        9'h0c3, 9'h115, 9'h0c4, 9'h120, 9'h0c6, 9'h10f,
        9'h0d0, 9'h1a4, 9'h1a1,
        9'h0e0, 9'h1d0, 9'h104, 9'h10d, 9'h111, 9'h113, 9'h12b, 9'h13f,
        9'h154, 9'h14c, 9'h118, 9'h10d, 9'h10b, 9'h11f, 9'h123,
        9'h0e1, 9'h1d0, 9'h104, 9'h10c, 9'h111, 9'h113, 9'h12c, 9'h13f,
        9'h144, 9'h151, 9'h12f, 9'h11f, 9'h11f, 9'h120, 9'h123,
        9'h021, 9'h029
    };

    lcd_init_seq_if bus ();
    assign bus.wr_done = ack | stray;

    lcd_init_seq #(
        .T_RST_LOW  (10),
        .T_RST_WAIT (5),
        .T_SLPOUT   (8),
        .H_RES      (H),
        .V_RES      (V),
        .MADCTL     (8'h00),
        .CLR_COLOR  (16'hFFFF)
    ) dut (
        .sys_clk_50MHz (clk),
        .sys_rst_n     (rst_n),
        .wr            (bus),
        .reinit        (reinit),
        .fill_req      (fill_req),
        .fill_x0       (fx0),
        .fill_x1       (fx1),
        .fill_y0       (fy0),
        .fill_y1       (fy1),
        .fill_color    (fcol),
        .lcd_rst       (lcd_rst),
        .init_done     (init_done),
        .fill_done     (fill_done),
        .fill_err      (fill_err)
    );

    always #5 clk = ~clk;

    // Writer model: ack the presented word on the third cycle it is offered.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.en_write) begin
                wcnt++;
                if (wcnt == 3) begin
                    cap_q.push_back(bus.init_data);
                    ack  = 1'b1;
                    wcnt = 0;
                end else begin
                    ack = 1'b0;
                end
            end else begin
                ack  = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Count pulse-output cycles.
    always @(negedge clk) begin
        if (fill_done) fd_cnt <= fd_cnt + 1;
        if (fill_err)  fe_cnt <= fe_cnt + 1;
    end

    function automatic bit model_ok(input int x0, input int x1, input int y0, input int y1);
        return (x1 >= x0) && (y1 >= y0) && (x1 < H) && (y1 < V);
    endfunction

    task automatic model_window(input int x0, input int x1, input int y0, input int y1);
        exp_q.push_back(9'h02a);
        exp_q.push_back(9'(256 + (x0 >> 8)));
        exp_q.push_back(9'(256 + (x0 & 255)));
        exp_q.push_back(9'(256 + (x1 >> 8)));
        exp_q.push_back(9'(256 + (x1 & 255)));
        exp_q.push_back(9'h02b);
        exp_q.push_back(9'(256 + (y0 >> 8)));
        exp_q.push_back(9'(256 + (y0 & 255)));
        exp_q.push_back(9'(256 + (y1 >> 8)));
        exp_q.push_back(9'(256 + (y1 & 255)));
        exp_q.push_back(9'h02c);
    endtask

    task automatic model_fill(input int x0, input int x1, input int y0, input int y1, input int color);
        int pixels;
        pixels = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int n = 0; n < pixels; n++) begin
            exp_q.push_back(9'(256 + ((color >> 8) & 255)));
            exp_q.push_back(9'(256 + (color & 255)));
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (lcd_rst !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_rst: got %b expected 0", lcd_rst); end
        vectors++; if (bus.init_data !== 9'h000) begin miscompares++; $display("FAIL reset_init_data: got %h expected 000", bus.init_data); end
        vectors++; if (bus.en_write !== 1'b0) begin miscompares++; $display("FAIL reset_en_write: got %b expected 0", bus.en_write); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        vectors++; if (fill_done !== 1'b0) begin miscompares++; $display("FAIL reset_fill_done: got %b expected 0", fill_done); end
        vectors++; if (fill_err !== 1'b0) begin miscompares++; $display("FAIL reset_fill_err: got %b expected 0", fill_err); end
        rst_n = 1'b1;
    endtask

    // Entered at the negedge right after reset release or the reinit edge.
    task automatic test_powerup(input bit poke);
        int n, base, gap, en_hi, fd0, fe0;
        bit seen_en;
        exp_q.delete();
        foreach (rom_tbl[i]) exp_q.push_back(rom_tbl[i]);
        model_window(0, H - 1, 0, V - 1);
        model_fill(0, H - 1, 0, V - 1, 16'hFFFF);
        base = cap_q.size(); fd0 = fd_cnt; fe0 = fe_cnt;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (lcd_rst !== 1'b1 && n < 100);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL rst_low_cycles: got %0d expected 10", n); end
        gap = 0; en_hi = 0; seen_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            fill_req = 1'b0;
            if (bus.en_write) begin seen_en = 1'b1; en_hi++; end
            if (poke && bus.en_write && en_hi == 20) begin
                fx0 = 9'd1; fx1 = 9'd2; fy0 = 9'd0; fy1 = 9'd1; fcol = 16'hF800;
                fill_req = 1'b1;
            end
            if (seen_en && !bus.en_write && lcd_rst && !init_done) gap++;
            stray = (!bus.en_write && lcd_rst && !init_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (init_done) break;
        end
        stray = 1'b0; fill_req = 1'b0;
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL powerup_done_timeout: got %b expected 1", init_done); end
        vectors++; if (gap !== 8) begin miscompares++; $display("FAIL slpout_gap: got %0d expected 8", gap); end
        repeat (2) @(negedge clk);
        vectors++; if (bus.en_write !== 1'b0 || bus.init_data !== 9'h000) begin miscompares++; $display("FAIL done_idle_bus: got en=%b data=%h expected en=0 data=000", bus.en_write, bus.init_data); end
        vectors++; if (fd_cnt - fd0 !== 0) begin miscompares++; $display("FAIL powerup_fill_done: got %0d expected 0", fd_cnt - fd0); end
        vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL powerup_fill_err: got %0d expected 0", fe_cnt - fe0); end
        vectors++; if (cap_q.size() - base !== exp_q.size()) begin miscompares++; $display("FAIL powerup_len: got %0d expected %0d", cap_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (base + i >= cap_q.size()) begin
                miscompares++; $display("FAIL powerup_word[%0d]: got none expected %h", i, exp_q[i]);
            end else if (cap_q[base + i] !== exp_q[i]) begin
                miscompares++; $display("FAIL powerup_word[%0d]: got %h expected %h", i, cap_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_fill(input int x0, input int x1, input int y0, input int y1, input int color);
        int base, fd0, fe0;
        bit ok, bad;
        ok = model_ok(x0, x1, y0, y1);
        exp_q.delete();
        if (ok) begin
            model_window(x0, x1, y0, y1);
            model_fill(x0, x1, y0, y1, color);
        end
        base = cap_q.size(); fd0 = fd_cnt; fe0 = fe_cnt;
        @(negedge clk);
        fx0 = 9'(x0); fx1 = 9'(x1); fy0 = 9'(y0); fy1 = 9'(y1); fcol = 16'(color);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        if (ok) begin
            vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL fill_accept_drop: got %b expected 0", init_done); end
            for (int c = 0; c < 3000 && init_done !== 1'b1; c++) @(negedge clk);
            vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL fill_timeout: got %b expected 1", init_done); end
            repeat (2) @(negedge clk);
            vectors++; if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL fill_done_count: got %0d expected 1", fd_cnt - fd0); end
            vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL fill_err_count: got %0d expected 0", fe_cnt - fe0); end
            vectors++; if (cap_q.size() - base !== exp_q.size()) begin miscompares++; $display("FAIL fill_len: got %0d expected %0d", cap_q.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (base + i >= cap_q.size()) begin
                    miscompares++; $display("FAIL fill_word[%0d]: got none expected %h", i, exp_q[i]);
                end else if (cap_q[base + i] !== exp_q[i]) begin
                    miscompares++; $display("FAIL fill_word[%0d]: got %h expected %h", i, cap_q[base + i], exp_q[i]);
                end
            end
        end else begin
            bad = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (init_done !== 1'b1 || bus.en_write !== 1'b0) bad = 1'b1;
                @(negedge clk);
            end
            vectors++; if (bad) begin miscompares++; $display("FAIL reject_idle: got init_done=%b en=%b expected 1/0", init_done, bus.en_write); end
            vectors++; if (fe_cnt - fe0 !== 1) begin miscompares++; $display("FAIL reject_err_count: got %0d expected 1", fe_cnt - fe0); end
            vectors++; if (fd_cnt - fd0 !== 0) begin miscompares++; $display("FAIL reject_done_count: got %0d expected 0", fd_cnt - fd0); end
            vectors++; if (cap_q.size() !== base) begin miscompares++; $display("FAIL reject_words: got %0d expected 0", cap_q.size() - base); end
        end
    endtask

    task automatic test_reinit();
        int base;
        base = cap_q.size();
        @(negedge clk);
        fx0 = 9'd0; fx1 = 9'(H - 1); fy0 = 9'd0; fy1 = 9'(V - 1); fcol = 16'h1234;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        for (int c = 0; c < 500 && cap_q.size() < base + 14; c++) @(negedge clk);
        vectors++; if (cap_q.size() < base + 14) begin miscompares++; $display("FAIL reinit_reach_fill: got %0d expected >=14", cap_q.size() - base); end
        reinit = 1'b1; fill_req = 1'b1;
        @(negedge clk);
        reinit = 1'b0; fill_req = 1'b0;
        vectors++; if (lcd_rst !== 1'b0) begin miscompares++; $display("FAIL reinit_lcd_rst: got %b expected 0", lcd_rst); end
        vectors++; if (bus.en_write !== 1'b0) begin miscompares++; $display("FAIL reinit_en_write: got %b expected 0", bus.en_write); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reinit_init_done: got %b expected 0", init_done); end
        test_powerup(1'b0);
    endtask

    task automatic test_async_reset();
        int base;
        base = cap_q.size();
        @(negedge clk);
        fx0 = 9'd0; fx1 = 9'd3; fy0 = 9'd0; fy1 = 9'd2; fcol = 16'h0F0F;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        for (int c = 0; c < 500 && cap_q.size() < base + 5; c++) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (bus.en_write !== 1'b0 || bus.init_data !== 9'h000) begin miscompares++; $display("FAIL async_rst_bus: got en=%b data=%h expected 0/000", bus.en_write, bus.init_data); end
        vectors++; if (lcd_rst !== 1'b0 || init_done !== 1'b0) begin miscompares++; $display("FAIL async_rst_ctrl: got lcd_rst=%b init_done=%b expected 0/0", lcd_rst, init_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_powerup(1'b0);
    endtask

    initial begin
        int x0, x1, y0, y1, col;
        test_reset();
        test_powerup(1'b1);
        test_fill(1, 2, 0, 1, 16'hF800);
        test_fill(1, 4, 0, 1, 16'h07E0);
        test_fill(0, 3, 0, 3, 16'h001F);
        test_fill(2, 1, 0, 1, 16'hAAAA);
        test_fill(0, 0, 2, 1, 16'h5555);
        test_fill(0, H - 1, 0, V - 1, 16'hC3A5);
        test_fill(3, 3, 2, 2, 16'h8001);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                x0 = $urandom_range(0, H - 1); x1 = $urandom_range(x0, H - 1);
                y0 = $urandom_range(0, V - 1); y1 = $urandom_range(y0, V - 1);
            end else begin
                x0 = $urandom_range(0, 511); x1 = $urandom_range(0, 511);
                y0 = $urandom_range(0, 511); y1 = $urandom_range(0, 511);
            end
            col = $urandom_range(0, 65535);
            test_fill(x0, x1, y0, y1, col);
        end
        test_reinit();
        test_fill(0, 1, 1, 2, 16'h7BEF);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
